alu_op_sequencer: RTL and testbench

- Front-end controller for the 4-bit ALU and its 6-way result mux (six 4-bit operation slots, 8-bit result).
- Accepts one operation request (opcode plus two 4-bit operands) over a valid/ready handshake and drives the ALU operands and mux select as registered signals.
- Waits a fixed settle time, captures the 8-bit mux output and returns it over a valid/ready response handshake.
- Out-of-range opcodes are rejected with an error response and never reach the datapath.

---
 rtl/alu_op_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU request, holds operands/select for SETTLE_CYCLES,
// captures the result mux output and returns it; illegal opcodes get an error response.
// Ports: clk, rst_n, req_valid/req_ready/req_op/req_a/req_b, alu_a/alu_b/mux_sel,
// alu_result, rsp_valid/rsp_ready/rsp_data/rsp_err, busy.
// Optional macro ALU_SEQ_FLAGS_EN adds registered rsp_zero / rsp_ovf outputs.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_OPS       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [3:0] req_a,
  input  logic [3:0] req_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] mux_sel,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic       rsp_zero,
  output logic       rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] NOPS     = 4'(NUM_OPS);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] a_d, b_d;
  logic [2:0] sel_d;
  logic [7:0] data_d;
  logic       err_d;
  logic       legal;
`ifdef ALU_SEQ_FLAGS_EN
  logic       zero_d, ovf_d;
`endif

  assign legal     = {1'b0, req_op} < NOPS;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = alu_a;
    b_d     = alu_b;
    sel_d   = mux_sel;
    data_d  = rsp_data;
    err_d   = rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d  = rsp_zero;
    ovf_d   = rsp_ovf;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (legal) begin
            a_d     = req_a;
            b_d     = req_b;
            sel_d   = req_op;
            cnt_d   = CNT_INIT;
            state_d = SETTLE;
          end else begin
            // illegal ops bypass the datapath entirely
            data_d  = 8'h00;
            err_d   = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            zero_d  = 1'b0;
            ovf_d   = 1'b0;
`endif
            state_d = RESP;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          data_d  = alu_result;
          err_d   = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d  = (alu_result == 8'h00);
          ovf_d   = |alu_result[7:4];
`endif
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      alu_a    <= 4'd0;
      alu_b    <= 4'd0;
      mux_sel  <= 3'd0;
      rsp_data <= 8'd0;
      rsp_err  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a    <= a_d;
      alu_b    <= b_d;
      mux_sel  <= sel_d;
      rsp_data <= data_d;
      rsp_err  <= err_d;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero <= zero_d;
      rsp_ovf  <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random checks of alu_op_sequencer
// against a transaction-level reference model (two instances, SETTLE 3 and 1).
module tb_alu_op_sequencer;

  localparam int S = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance signals (SETTLE_CYCLES = 3)
  logic       m_req_valid = 1'b0, m_req_ready;
  logic [2:0] m_req_op = 3'd0;
  logic [3:0] m_req_a = 4'd0, m_req_b = 4'd0;
  logic [3:0] m_alu_a, m_alu_b;
  logic [2:0] m_mux_sel;
  logic [7:0] m_alu_result;
  logic       m_rsp_valid, m_rsp_ready = 1'b0;
  logic [7:0] m_rsp_data;
  logic       m_rsp_err, m_busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic       m_rsp_zero, m_rsp_ovf;
`endif

  // second instance signals (SETTLE_CYCLES = 1)
  logic       s_req_valid = 1'b0, s_req_ready;
  logic [2:0] s_req_op = 3'd0;
  logic [3:0] s_req_a = 4'd0, s_req_b = 4'd0;
  logic [3:0] s_alu_a, s_alu_b;
  logic [2:0] s_mux_sel;
  logic [7:0] s_alu_result;
  logic       s_rsp_valid, s_rsp_ready = 1'b1;
  logic [7:0] s_rsp_data;
  logic       s_rsp_err, s_busy;
`ifdef ALU_SEQ_FLAGS_EN
  logic       s_rsp_zero, s_rsp_ovf;
`endif

  // behavioural ALU: slot results from plain arithmetic
  function automatic logic [7:0] ref_alu(input logic [2:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
    logic [7:0] xa, xb;
    xa = {4'd0, a};
    xb = {4'd0, b};
    case (op)
      3'd0: return xa + xb;
      3'd1: return xa - xb;
      3'd2: return xa & xb;
      3'd3: return xa | xb;
      3'd4: return xa ^ xb;
      3'd5: return xa * xb;
      default: return 8'h00;
    endcase
  endfunction

  // the main ALU output also carries the cycle count, so the exact
  // sampling cycle is visible in the captured value
  assign m_alu_result = ref_alu(m_mux_sel, m_alu_a, m_alu_b) ^ 8'(cyc);
  assign s_alu_result = ref_alu(s_mux_sel, s_alu_a, s_alu_b);

  alu_op_sequencer #(.SETTLE_CYCLES(S), .NUM_OPS(6)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_op(m_req_op), .req_a(m_req_a), .req_b(m_req_b),
    .alu_a(m_alu_a), .alu_b(m_alu_b), .mux_sel(m_mux_sel),
    .alu_result(m_alu_result),
    .rsp_valid(m_rsp_valid), .rsp_ready(m_rsp_ready),
    .rsp_data(m_rsp_data), .rsp_err(m_rsp_err), .busy(m_busy)
`ifdef ALU_SEQ_FLAGS_EN
    , .rsp_zero(m_rsp_zero), .rsp_ovf(m_rsp_ovf)
`endif
  );

  alu_op_sequencer #(.SETTLE_CYCLES(1), .NUM_OPS(6)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_op(s_req_op), .req_a(s_req_a), .req_b(s_req_b),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .mux_sel(s_mux_sel),
    .alu_result(s_alu_result),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_data(s_rsp_data), .rsp_err(s_rsp_err), .busy(s_busy)
`ifdef ALU_SEQ_FLAGS_EN
    , .rsp_zero(s_rsp_zero), .rsp_ovf(s_rsp_ovf)
`endif
  );

  // model of the last legal request (operand/select registers)
  logic [3:0] exp_a = 4'd0, exp_b = 4'd0;
  logic [2:0] exp_sel = 3'd0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int stall);
    int acc;
    logic [7:0] ed;
    logic ee;
    chk("m_idle_ready", m_req_ready, 1);
    m_req_op = op;
    m_req_a = a;
    m_req_b = b;
    m_req_valid = 1'b1;
    m_rsp_ready = (stall == 0);
    tick();
    acc = cyc;
    m_req_valid = 1'b0;
    chk("m_busy_acc", m_busy, 1);
    if (op < 3'd6) begin
      exp_a = a;
      exp_b = b;
      exp_sel = op;
      // capture edge is acc+S, sampling the value present before it
      ed = ref_alu(op, a, b) ^ 8'(acc + S - 1);
      ee = 1'b0;
      chk("m_alu_a", m_alu_a, exp_a);
      chk("m_alu_b", m_alu_b, exp_b);
      chk("m_mux_sel", m_mux_sel, exp_sel);
      for (int i = 0; i < S; i++) begin
        chk("m_settle_novalid", m_rsp_valid, 0);
        tick();
      end
    end else begin
      ed = 8'h00;
      ee = 1'b1;
      chk("m_ill_sel_kept", m_mux_sel, exp_sel);
      chk("m_ill_a_kept", m_alu_a, exp_a);
    end
    chk("m_rsp_valid", m_rsp_valid, 1);
    chk("m_rsp_data", m_rsp_data, ed);
    chk("m_rsp_err", m_rsp_err, ee);
`ifdef ALU_SEQ_FLAGS_EN
    chk("m_rsp_zero", m_rsp_zero, !ee && ed == 8'h00);
    chk("m_rsp_ovf", m_rsp_ovf, !ee && ed[7:4] != 4'd0);
`endif
    if (stall > 0) begin
      // competing request held during backpressure must be ignored
      m_req_op = 3'd2;
      m_req_a = ~a;
      m_req_b = ~b;
      m_req_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        tick();
        chk("m_bp_valid", m_rsp_valid, 1);
        chk("m_bp_data", m_rsp_data, ed);
        chk("m_bp_err", m_rsp_err, ee);
        chk("m_bp_req_ready", m_req_ready, 0);
        chk("m_bp_sel", m_mux_sel, exp_sel);
      end
      m_req_valid = 1'b0;
      m_rsp_ready = 1'b1;
    end
    tick();
    chk("m_hs_valid", m_rsp_valid, 0);
    chk("m_hs_busy", m_busy, 0);
    chk("m_hs_data_hold", m_rsp_data, ed);
    chk("m_hs_sel", m_mux_sel, exp_sel);
  endtask

  task automatic run_s1(input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] ed);
    s_req_op = op;
    s_req_a = a;
    s_req_b = b;
    s_req_valid = 1'b1;
    s_rsp_ready = 1'b1;
    tick();
    s_req_valid = 1'b0;
    chk("s_alu_a", s_alu_a, a);
    chk("s_alu_b", s_alu_b, b);
    chk("s_mux_sel", s_mux_sel, op);
    chk("s_settle_novalid", s_rsp_valid, 0);
    tick();
    chk("s_rsp_valid", s_rsp_valid, 1);
    chk("s_rsp_data", s_rsp_data, ed);
`ifdef ALU_SEQ_FLAGS_EN
    chk("s_rsp_zero", s_rsp_zero, ed == 8'h00);
    chk("s_rsp_ovf", s_rsp_ovf, ed[7:4] != 4'd0);
`endif
    tick();
    chk("s_back_idle", s_rsp_valid, 0);
    chk("s_req_ready", s_req_ready, 1);
  endtask

  initial begin
    #3;
    chk("rst_alu_a", m_alu_a, 0);
    chk("rst_alu_b", m_alu_b, 0);
    chk("rst_mux_sel", m_mux_sel, 0);
    chk("rst_rsp_data", m_rsp_data, 0);
    chk("rst_rsp_valid", m_rsp_valid, 0);
    chk("rst_rsp_err", m_rsp_err, 0);
    chk("rst_busy", m_busy, 0);
    chk("rst_s_busy", s_busy, 0);
    #14 rst_n = 1'b1;
    tick();

    // SETTLE_CYCLES=1 directed ops
    run_s1(3'd0, 4'h3, 4'h5, 8'h08);
    run_s1(3'd2, 4'h3, 4'h4, 8'h00);
    run_s1(3'd0, 4'hF, 4'hF, 8'h1E);

    // SETTLE_CYCLES=3 directed: slot 5, illegal ops, backpressure
    run_op(3'd5, 4'hF, 4'hF, 0);
    run_op(3'd6, 4'h1, 4'h2, 0);
    run_op(3'd7, 4'h4, 4'h9, 2);
    run_op(3'd1, 4'h2, 4'h7, 10);

    // random traffic
    for (int n = 0; n < 30; n++) begin
      run_op(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
             int'($urandom_range(0, 3)));
    end

    // asynchronous reset in the middle of SETTLE
    m_req_op = 3'd4;
    m_req_a = 4'hA;
    m_req_b = 4'h6;
    m_req_valid = 1'b1;
    m_rsp_ready = 1'b1;
    tick();
    m_req_valid = 1'b0;
    chk("ar_busy_pre", m_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_alu_a", m_alu_a, 0);
    chk("ar_alu_b", m_alu_b, 0);
    chk("ar_mux_sel", m_mux_sel, 0);
    chk("ar_rsp_data", m_rsp_data, 0);
    chk("ar_rsp_valid", m_rsp_valid, 0);
    chk("ar_busy", m_busy, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ar_no_rsp", m_rsp_valid, 0);
      chk("ar_idle", m_busy, 0);
    end
    exp_a = 4'd0;
    exp_b = 4'd0;
    exp_sel = 3'd0;
    run_op(3'd3, 4'h5, 4'hA, 1);
    run_op(3'd6, 4'h0, 4'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
